// File: rtl/ttl_reg_pipe_if.sv
// ttl_reg_pipe_if: handshake bundle for ttl_reg_pipe.
// The upstream valid/ready/data, the downstream valid/ready/data and the
// occupancy count are grouped here. The pipeline itself uses the slave view.
// The producer/consumer side uses the master view.
interface ttl_reg_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] D;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] Q;
    logic [OCC_W-1:0] OCCUPANCY;

    modport master (
        output IN_VALID, D, OUT_READY,
        input  IN_READY, OUT_VALID, Q, OCCUPANCY
    );

    modport slave (
        input  IN_VALID, D, OUT_READY,
        output IN_READY, OUT_VALID, Q, OCCUPANCY
    );
endinterface

// File: rtl/ttl_reg_pipe.sv
// ttl_reg_pipe: WIDTH-bit, DEPTH-stage register pipeline with per-stage
// valid bits, a valid/ready handshake, bubble collapsing and a synchronous
// flush (SCLR). CLR is an asynchronous, active-high clear.
//
// Optional feature macro: TTL_REG_PIPE_HOLD_LAST_EN
//   defined     - a stage that empties keeps its data, so Q shows the last
//                 delivered word while OUT_VALID=0.
//   not defined - a stage that empties reloads RESET_VALUE, so
//                 Q=RESET_VALUE whenever OUT_VALID=0.
module ttl_reg_pipe #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             SCLR,
    ttl_reg_pipe_if.slave    bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [OCC_W-1:0] r_occ;

    logic [DEPTH-1:0] w_empty;     // stage i hands its word on this cycle
    logic [DEPTH-1:0] w_can_load;  // stage i is free or freeing this cycle
    logic [DEPTH-1:0] w_load;      // stage i captures a word this cycle
    logic [WIDTH-1:0] w_src [DEPTH];
    logic             w_in_ready;
    logic [OCC_W-1:0] w_occ_next;

    // Ready chain, evaluated from the output stage back towards stage 0.
    always_comb begin
        logic w_down_takes;
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        w_empty      = '0;
        w_can_load   = '0;
        w_down_takes = bus.OUT_READY;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_empty[i]    = r_valid[i] & w_down_takes;
            w_can_load[i] = ~r_valid[i] | w_down_takes;
            w_down_takes  = w_can_load[i];
        end
    end

    assign w_in_ready = w_can_load[0] & ~SCLR;

    // Per-stage load strobes and data sources (stage 0 takes D).
    always_comb begin
        w_load    = '0;
        w_src[0]  = bus.D;
        w_load[0] = bus.IN_VALID & w_in_ready;
        for (int i = 1; i < DEPTH; i++) begin
            w_src[i]  = r_data[i-1];
            w_load[i] = r_valid[i-1] & w_can_load[i];
        end
    end

    // Population count of the valid bits as they will be after this edge.
    always_comb begin
        w_occ_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ_next = w_occ_next + OCC_W'(w_load[i] | (r_valid[i] & ~w_empty[i]));
        end
    end

    // Stage registers: clear, flush, then per-stage load / empty / hold.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            // NOTE: the stage array is a bank of pipeline registers, not a
            // RAM, so resetting every entry is intended and cheap here.
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VALUE;
            end
            r_valid <= '0;
            r_occ   <= '0;
        end else if (SCLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VALUE;
            end
            r_valid <= '0;
            r_occ   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read the
            // pre-edge value of its upstream neighbour, which is what makes
            // the stages shift together instead of rippling in one edge.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    r_data[i]  <= w_src[i];
                    r_valid[i] <= 1'b1;
                end else if (w_empty[i]) begin
                    r_valid[i] <= 1'b0;
`ifdef TTL_REG_PIPE_HOLD_LAST_EN
                    r_data[i]  <= r_data[i];
`else
                    r_data[i]  <= RESET_VALUE;
`endif
                end
            end
            r_occ <= w_occ_next;
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.OUT_VALID = r_valid[DEPTH-1];
    assign bus.Q         = r_data[DEPTH-1];
    assign bus.OCCUPANCY = r_occ;

endmodule

// File: tb/tb_ttl_reg_pipe.sv
// tb_ttl_reg_pipe: directed plus random stimulus for ttl_reg_pipe (WIDTH=8,
// DEPTH=3). The reference model tracks the words in flight as an ordered
// queue of (position, data) pairs. A word steps one position towards the
// output whenever the slot ahead of it is free or being vacated.
module tb_ttl_reg_pipe;
    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RST_V = 8'h00;

    logic clk = 1'b0;
    logic clr;
    logic sclr;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    ttl_reg_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ttl_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RST_V)) dut (
        .CLK  (clk),
        .CLR  (clr),
        .SCLR (sclr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: oldest word first.
    int         pos_q[$];
    logic [7:0] dat_q[$];
    bit         mv[$];
    logic [7:0] hold_q = RST_V;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void model_moves(input bit ordy);
        mv.delete();
        for (int k = 0; k < pos_q.size(); k++) begin
            if (k == 0)
                mv.push_back((pos_q[0] == DEPTH - 1) ? ordy : 1'b1);
            else
                mv.push_back((pos_q[k] + 1 < pos_q[k-1]) || mv[k-1]);
        end
    endfunction

    function automatic bit model_in_ready(input bit sc);
        if (sc) return 1'b0;
        if (pos_q.size() == 0) return 1'b1;
        return (pos_q[pos_q.size()-1] > 0) || mv[mv.size()-1];
    endfunction

    function automatic logic [7:0] model_q();
        if (pos_q.size() > 0 && pos_q[0] == DEPTH - 1) return dat_q[0];
`ifdef TTL_REG_PIPE_HOLD_LAST_EN
        return hold_q;
`else
        return RST_V;
`endif
    endfunction

    function automatic bit model_out_valid();
        return (pos_q.size() > 0) && (pos_q[0] == DEPTH - 1);
    endfunction

    task automatic model_clear();
        pos_q.delete();
        dat_q.delete();
        mv.delete();
        hold_q = RST_V;
    endtask

    // Apply one rising edge to the model with the given inputs.
    task automatic model_edge(input bit iv, input logic [7:0] d, input bit ordy, input bit sc);
        int         np[$];
        logic [7:0] nd[$];
        bit         acc;
        if (sc) begin
            model_clear();
            return;
        end
        model_moves(ordy);
        acc = iv && model_in_ready(1'b0);
        for (int k = 0; k < pos_q.size(); k++) begin
            if (!(k == 0 && pos_q[0] == DEPTH - 1 && mv[0])) begin
                np.push_back(pos_q[k] + (mv[k] ? 1 : 0));
                nd.push_back(dat_q[k]);
            end
        end
        if (acc) begin
            np.push_back(0);
            nd.push_back(d);
        end
        pos_q = np;
        dat_q = nd;
        if (pos_q.size() > 0 && pos_q[0] == DEPTH - 1) hold_q = dat_q[0];
    endtask

    // One clock cycle: drive at the falling edge, compare, advance the model.
    task automatic cycle(input bit iv, input logic [7:0] d, input bit ordy, input bit sc);
        @(negedge clk);
        cyc++;
        bus.IN_VALID  = iv;
        bus.D         = d;
        bus.OUT_READY = ordy;
        sclr          = sc;
        #1;
        model_moves(ordy);
        check("in_ready",  32'(bus.IN_READY),  32'(model_in_ready(sc)));
        check("out_valid", 32'(bus.OUT_VALID), 32'(model_out_valid()));
        check("q",         32'(bus.Q),         32'(model_q()));
        check("occupancy", 32'(bus.OCCUPANCY), 32'(pos_q.size()));
        model_edge(iv, d, ordy, sc);
    endtask

    // Asynchronous clear pulse between clock edges.
    task automatic clr_pulse();
        @(negedge clk);
        cyc++;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        sclr          = 1'b0;
        #1;
        clr = 1'b1;
        #1;
        check("clr_q",         32'(bus.Q),         32'(RST_V));
        check("clr_out_valid", 32'(bus.OUT_VALID), 32'h0);
        check("clr_occupancy", 32'(bus.OCCUPANCY), 32'h0);
        clr = 1'b0;
        #1;
        check("clr_in_ready",  32'(bus.IN_READY),  32'h1);
        model_clear();
    endtask

    initial begin
        clr           = 1'b1;
        sclr          = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.D         = '0;
        bus.OUT_READY = 1'b0;
        #2;
        check("rst_q",         32'(bus.Q),         32'(RST_V));
        check("rst_out_valid", 32'(bus.OUT_VALID), 32'h0);
        check("rst_occupancy", 32'(bus.OCCUPANCY), 32'h0);
        check("rst_in_ready",  32'(bus.IN_READY),  32'h1);
        #10;
        clr = 1'b0;

        // Back-to-back stream with the consumer always ready, then drain.
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        cycle(1'b1, 8'h22, 1'b1, 1'b0);
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Stalled consumer: three words fit, the fourth waits, then release.
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        cycle(1'b1, 8'h43, 1'b0, 1'b0);
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        cycle(1'b1, 8'h44, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Single word collapses to the last stage while the consumer stalls.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush while full and a producer is offering a word.
        repeat (3) cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        cycle(1'b1, 8'hC4, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Deliver one word, then idle: Q either holds it or returns to reset.
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous clear with two words held mid-stall.
        cycle(1'b1, 8'h71, 1'b0, 1'b0);
        cycle(1'b1, 8'h72, 1'b0, 1'b0);
        clr_pulse();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        repeat (400) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
